id_ex_pipe_reg: RTL and testbench
=================================

Name: id_ex_pipe_reg

Overview:
- ID/EX pipeline register of the 5-stage RISC-V core, directly downstream of the decode-stage control unit and register file.
- Captures decoded control bits, operand data, immediate, function fields and register addresses each cycle and presents them to EX.
- Supports stall (hold), flush (bubble insertion) and upstream-invalid bubbles, and keeps a saturating bubble counter for performance and debug.

Parameters:
DATA_W, 32, width of operand, immediate and PC fields
CNT_W, 16, width of bubble counter

Ports:
clk_i  in  1  clock, all state updates on rising edge
rst_i  in  1  asynchronous reset, active-high
stall_i  in  1  hold all registered contents this cycle
flush_i  in  1  replace contents with a bubble this cycle
valid_i  in  1  ID-stage instruction is real; 0 means latch a bubble
RegWrite_i  in  1  control from decode
MemtoReg_i  in  1  control from decode
MemRead_i  in  1  control from decode
MemWrite_i  in  1  control from decode
Branch_i  in  1  control from decode
ALUSrc_i  in  1  control from decode
ALUOp_i  in  2  control from decode
rs1_data_i  in  DATA_W  register file read port 1
rs2_data_i  in  DATA_W  register file read port 2
imm_i  in  DATA_W  sign-extended immediate
pc_i  in  DATA_W  PC of ID instruction
funct_i  in  10  {funct7, funct3}
rs1_addr_i  in  5  source 1 index (forwarding)
rs2_addr_i  in  5  source 2 index (forwarding)
rd_addr_i  in  5  destination index
*_o  out  same  registered copies of every input above from RegWrite_i through rd_addr_i
valid_o  out  1  EX-stage instruction is real
bubble_cnt_o  out  CNT_W  number of bubbles latched since reset, saturating

Behaviour:
- Reset (async, rst_i=1): all outputs 0 immediately, independent of clk_i; held while rst_i=1. First capture on the first rising edge after deassertion.
- Per-edge priority: flush > stall > load.
- Flush (flush_i=1, overrides stall_i): all control outputs, valid_o, rd_addr_o, rs1_addr_o and rs2_addr_o become 0. Data, imm, pc and funct outputs also become 0 for determinism.
- Stall (flush_i=0, stall_i=1): every output, including valid_o, holds its value. bubble_cnt_o unchanged.
- Load (flush_i=0, stall_i=0):
  - valid_i=1: all fields capture their inputs; valid_o=1.
  - valid_i=0: data and address fields capture their inputs; control outputs, rd_addr_o and valid_o are forced 0, so the EX stage sees no side effects.
- Latency: exactly one cycle from input to output on load; no combinational path input->output.
- Bubble counter: +1 on each edge where a flush occurs, or a load occurs with valid_i=0.
  - Stall cycles do not count.
  - Saturates at 2^CNT_W-1; no wrap.
  - Reset clears to 0.
- Invariant: valid_o=0 implies RegWrite_o=MemRead_o=MemWrite_o=Branch_o=0.
- Reset asserted mid-stall or mid-flush: reset wins immediately; no held state survives.
- Inputs X while stall_i=1: outputs remain stable and non-X.

Test Plan:
- Reset with inputs driven: rst_i=1 asynchronously mid-cycle with RegWrite_i=1, rs1_data_i=32'hDEADBEEF -> all outputs 0 before the next edge; bubble_cnt_o=0.
- Normal load: valid_i=1, RegWrite_i=1, ALUOp_i=2'b10, rs1_data_i=5, rs2_data_i=7, rd_addr_i=3 -> next cycle same values on outputs, valid_o=1.
- Stall hold: after load, stall_i=1 for 3 cycles while inputs change to rd_addr_i=9 -> outputs keep rd_addr_o=3, valid_o=1 for all 3 cycles; bubble_cnt_o unchanged.
- Flush over stall: stall_i=1 and flush_i=1 on the same edge after a MemWrite_i=1 load -> MemWrite_o=0, valid_o=0, rd_addr_o=0; bubble_cnt_o increments by 1.
- Upstream bubble: valid_i=0 with RegWrite_i=1, rd_addr_i=5, rs1_data_i=11 -> RegWrite_o=0, rd_addr_o=0, valid_o=0, rs1_data_o=11; bubble_cnt_o+1.
- Saturation with CNT_W=4: 20 consecutive flushes -> bubble_cnt_o reaches 15 and stays 15.

Source files
------------

// File: rtl/id_ex_pipe_reg.sv
//------------------------------------------------------------------------------
// Module      : id_ex_pipe_reg
// Description : ID/EX pipeline register with stall, flush and bubble insertion,
//               plus a saturating count of the bubbles it has latched.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module id_ex_pipe_reg #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              stall_i,
    input  logic              flush_i,
    input  logic              valid_i,
    input  logic              RegWrite_i,
    input  logic              MemtoReg_i,
    input  logic              MemRead_i,
    input  logic              MemWrite_i,
    input  logic              Branch_i,
    input  logic              ALUSrc_i,
    input  logic [1:0]        ALUOp_i,
    input  logic [DATA_W-1:0] rs1_data_i,
    input  logic [DATA_W-1:0] rs2_data_i,
    input  logic [DATA_W-1:0] imm_i,
    input  logic [DATA_W-1:0] pc_i,
    input  logic [9:0]        funct_i,
    input  logic [4:0]        rs1_addr_i,
    input  logic [4:0]        rs2_addr_i,
    input  logic [4:0]        rd_addr_i,
    output logic              RegWrite_o,
    output logic              MemtoReg_o,
    output logic              MemRead_o,
    output logic              MemWrite_o,
    output logic              Branch_o,
    output logic              ALUSrc_o,
    output logic [1:0]        ALUOp_o,
    output logic [DATA_W-1:0] rs1_data_o,
    output logic [DATA_W-1:0] rs2_data_o,
    output logic [DATA_W-1:0] imm_o,
    output logic [DATA_W-1:0] pc_o,
    output logic [9:0]        funct_o,
    output logic [4:0]        rs1_addr_o,
    output logic [4:0]        rs2_addr_o,
    output logic [4:0]        rd_addr_o,
    output logic              valid_o,
    output logic [CNT_W-1:0]  bubble_cnt_o
);

    localparam logic [CNT_W-1:0] c_CNT_MAX = '1;

    logic w_load;
    logic w_bubble;
    logic w_cnt_max;

    assign w_load    = !flush_i && !stall_i;
    assign w_bubble  = flush_i || (w_load && !valid_i);
    assign w_cnt_max = (bubble_cnt_o == c_CNT_MAX);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            RegWrite_o <= 1'b0;
            MemtoReg_o <= 1'b0;
            MemRead_o  <= 1'b0;
            MemWrite_o <= 1'b0;
            Branch_o   <= 1'b0;
            ALUSrc_o   <= 1'b0;
            ALUOp_o    <= '0;
            rs1_data_o <= '0;
            rs2_data_o <= '0;
            imm_o      <= '0;
            pc_o       <= '0;
            funct_o    <= '0;
            rs1_addr_o <= '0;
            rs2_addr_o <= '0;
            rd_addr_o  <= '0;
            valid_o    <= 1'b0;
        end else if (flush_i) begin
            RegWrite_o <= 1'b0;
            MemtoReg_o <= 1'b0;
            MemRead_o  <= 1'b0;
            MemWrite_o <= 1'b0;
            Branch_o   <= 1'b0;
            ALUSrc_o   <= 1'b0;
            ALUOp_o    <= '0;
            rs1_data_o <= '0;
            rs2_data_o <= '0;
            imm_o      <= '0;
            pc_o       <= '0;
            funct_o    <= '0;
            rs1_addr_o <= '0;
            rs2_addr_o <= '0;
            rd_addr_o  <= '0;
            valid_o    <= 1'b0;
        end else if (!stall_i) begin
            // Upstream bubbles keep their operands but must never cause a side effect in EX.
            RegWrite_o <= valid_i & RegWrite_i;
            MemtoReg_o <= valid_i & MemtoReg_i;
            MemRead_o  <= valid_i & MemRead_i;
            MemWrite_o <= valid_i & MemWrite_i;
            Branch_o   <= valid_i & Branch_i;
            ALUSrc_o   <= valid_i & ALUSrc_i;
            ALUOp_o    <= valid_i ? ALUOp_i : 2'b00;
            rs1_data_o <= rs1_data_i;
            rs2_data_o <= rs2_data_i;
            imm_o      <= imm_i;
            pc_o       <= pc_i;
            funct_o    <= funct_i;
            rs1_addr_o <= rs1_addr_i;
            rs2_addr_o <= rs2_addr_i;
            rd_addr_o  <= valid_i ? rd_addr_i : 5'd0;
            valid_o    <= valid_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            bubble_cnt_o <= '0;
        end else if (w_bubble && !w_cnt_max) begin
            bubble_cnt_o <= bubble_cnt_o + 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_id_ex_pipe_reg.sv
//------------------------------------------------------------------------------
// Module      : tb_id_ex_pipe_reg
// Description : Self-checking bench for id_ex_pipe_reg (vector table + random).
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_id_ex_pipe_reg;

    typedef struct packed {
        logic [7:0]  ctrl;   // {RegWrite, MemtoReg, MemRead, MemWrite, Branch, ALUSrc, ALUOp[1:0]}
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] imm;
        logic [31:0] pc;
        logic [9:0]  funct;
        logic [4:0]  a1;
        logic [4:0]  a2;
        logic [4:0]  rd;
        logic        valid;
    } fields_t;

    typedef struct {
        logic    stall;
        logic    flush;
        fields_t fin;
        fields_t fexp;
        int      cnt;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        flush;
    fields_t     in_f;
    fields_t     out_f;
    fields_t     out2_f;
    logic [15:0] cnt;
    logic [3:0]  cnt4;

    int ntot = 0;
    int nbad = 0;

    always #5 clk = ~clk;

    id_ex_pipe_reg #(.DATA_W(32), .CNT_W(16)) dut (
        .clk_i(clk), .rst_i(rst), .stall_i(stall), .flush_i(flush), .valid_i(in_f.valid),
        .RegWrite_i(in_f.ctrl[7]), .MemtoReg_i(in_f.ctrl[6]), .MemRead_i(in_f.ctrl[5]),
        .MemWrite_i(in_f.ctrl[4]), .Branch_i(in_f.ctrl[3]), .ALUSrc_i(in_f.ctrl[2]),
        .ALUOp_i(in_f.ctrl[1:0]), .rs1_data_i(in_f.rs1), .rs2_data_i(in_f.rs2),
        .imm_i(in_f.imm), .pc_i(in_f.pc), .funct_i(in_f.funct), .rs1_addr_i(in_f.a1),
        .rs2_addr_i(in_f.a2), .rd_addr_i(in_f.rd),
        .RegWrite_o(out_f.ctrl[7]), .MemtoReg_o(out_f.ctrl[6]), .MemRead_o(out_f.ctrl[5]),
        .MemWrite_o(out_f.ctrl[4]), .Branch_o(out_f.ctrl[3]), .ALUSrc_o(out_f.ctrl[2]),
        .ALUOp_o(out_f.ctrl[1:0]), .rs1_data_o(out_f.rs1), .rs2_data_o(out_f.rs2),
        .imm_o(out_f.imm), .pc_o(out_f.pc), .funct_o(out_f.funct), .rs1_addr_o(out_f.a1),
        .rs2_addr_o(out_f.a2), .rd_addr_o(out_f.rd), .valid_o(out_f.valid),
        .bubble_cnt_o(cnt)
    );

    // Narrow-counter instance shares all stimulus; used for the saturation checks.
    id_ex_pipe_reg #(.DATA_W(32), .CNT_W(4)) dut4 (
        .clk_i(clk), .rst_i(rst), .stall_i(stall), .flush_i(flush), .valid_i(in_f.valid),
        .RegWrite_i(in_f.ctrl[7]), .MemtoReg_i(in_f.ctrl[6]), .MemRead_i(in_f.ctrl[5]),
        .MemWrite_i(in_f.ctrl[4]), .Branch_i(in_f.ctrl[3]), .ALUSrc_i(in_f.ctrl[2]),
        .ALUOp_i(in_f.ctrl[1:0]), .rs1_data_i(in_f.rs1), .rs2_data_i(in_f.rs2),
        .imm_i(in_f.imm), .pc_i(in_f.pc), .funct_i(in_f.funct), .rs1_addr_i(in_f.a1),
        .rs2_addr_i(in_f.a2), .rd_addr_i(in_f.rd),
        .RegWrite_o(out2_f.ctrl[7]), .MemtoReg_o(out2_f.ctrl[6]), .MemRead_o(out2_f.ctrl[5]),
        .MemWrite_o(out2_f.ctrl[4]), .Branch_o(out2_f.ctrl[3]), .ALUSrc_o(out2_f.ctrl[2]),
        .ALUOp_o(out2_f.ctrl[1:0]), .rs1_data_o(out2_f.rs1), .rs2_data_o(out2_f.rs2),
        .imm_o(out2_f.imm), .pc_o(out2_f.pc), .funct_o(out2_f.funct), .rs1_addr_o(out2_f.a1),
        .rs2_addr_o(out2_f.a2), .rd_addr_o(out2_f.rd), .valid_o(out2_f.valid),
        .bubble_cnt_o(cnt4)
    );

    task automatic chk_f(input string nm, input fields_t act, input fields_t exp);
        ntot++;
        if (act !== exp) begin
            nbad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_n(input string nm, input int act, input int exp);
        ntot++;
        if (act != exp) begin
            nbad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Reference behaviour: what EX should see after one edge, from the pipeline rules.
    function automatic fields_t model_next(fields_t cur, fields_t nin, logic s, logic f);
        fields_t r;
        if (f) return '0;
        if (s) return cur;
        r = nin;
        if (!nin.valid) begin
            r.ctrl = '0;
            r.rd   = '0;
        end
        return r;
    endfunction

    function automatic logic is_bubble(logic s, logic f, logic v);
        return f || (!s && !v);
    endfunction

    function automatic int sat(int n, int maxv);
        return (n > maxv) ? maxv : n;
    endfunction

    function automatic vec_t mkv(logic s, logic f, fields_t a, fields_t e, int c);
        vec_t v;
        v.stall = s; v.flush = f; v.fin = a; v.fexp = e; v.cnt = c;
        return v;
    endfunction

    vec_t    rows[7];
    fields_t m;
    int      bubbles;

    initial begin
        fields_t ld1, st, mw, ub, ube;

        rst = 1'b1; stall = 1'b0; flush = 1'b0; in_f = '0;
        #12;
        chk_f("reset_fields", out_f, '0);
        chk_n("reset_cnt", int'(cnt), 0);
        @(negedge clk);
        rst = 1'b0;

        ld1 = '0; ld1.ctrl = 8'b1000_0010; ld1.rs1 = 32'd5; ld1.rs2 = 32'd7; ld1.rd = 5'd3; ld1.valid = 1'b1;
        st = ld1; st.rd = 5'd9; st.rs1 = 32'd99;
        mw = '0; mw.ctrl = 8'b0001_0000; mw.rd = 5'd4; mw.rs1 = 32'd1; mw.valid = 1'b1;
        ub = '0; ub.ctrl = 8'b1000_0000; ub.rd = 5'd5; ub.rs1 = 32'd11; ub.a1 = 5'd2;
        ube = '0; ube.rs1 = 32'd11; ube.a1 = 5'd2;
        rows[0] = mkv(1'b0, 1'b0, ld1, ld1, 0);
        rows[1] = mkv(1'b1, 1'b0, st, ld1, 0);
        rows[2] = mkv(1'b1, 1'b0, st, ld1, 0);
        rows[3] = mkv(1'b1, 1'b0, st, ld1, 0);
        rows[4] = mkv(1'b0, 1'b0, mw, mw, 0);
        rows[5] = mkv(1'b1, 1'b1, mw, '0, 1);
        rows[6] = mkv(1'b0, 1'b0, ub, ube, 2);

        for (int i = 0; i < 7; i++) begin
            stall = rows[i].stall; flush = rows[i].flush; in_f = rows[i].fin;
            @(posedge clk); #1;
            chk_f($sformatf("vec%0d_fields", i), out_f, rows[i].fexp);
            chk_n($sformatf("vec%0d_cnt", i), int'(cnt), rows[i].cnt);
        end

        // Twenty back-to-back flushes: the 4-bit counter must pin at 15.
        bubbles = 2;
        flush = 1'b1; stall = 1'b0;
        for (int k = 0; k < 20; k++) begin
            in_f.rs1 = $urandom;
            @(posedge clk); #1;
            bubbles++;
            chk_n($sformatf("sat4_%0d", k), int'(cnt4), sat(bubbles, 15));
            chk_n($sformatf("cnt16_%0d", k), int'(cnt), bubbles);
        end
        chk_f("flush_train_fields", out_f, '0);

        // Load something, then reset asynchronously in the middle of a stall.
        flush = 1'b0; stall = 1'b0; in_f = ld1;
        @(posedge clk);
        @(negedge clk);
        stall = 1'b1; in_f.ctrl[7] = 1'b1; in_f.rs1 = 32'hDEADBEEF;
        rst = 1'b1;
        #1;
        chk_f("async_rst_fields", out_f, '0);
        chk_n("async_rst_cnt", int'(cnt), 0);
        chk_n("async_rst_cnt4", int'(cnt4), 0);
        @(posedge clk); #1;
        chk_f("rst_held_fields", out_f, '0);
        @(negedge clk);
        rst = 1'b0; stall = 1'b0;

        m = '0;
        bubbles = 0;
        for (int n = 0; n < 500; n++) begin
            flush = ($urandom_range(0, 7) == 0);
            stall = ($urandom_range(0, 3) == 0);
            in_f.ctrl  = 8'($urandom);
            in_f.rs1   = $urandom;
            in_f.rs2   = $urandom;
            in_f.imm   = $urandom;
            in_f.pc    = $urandom;
            in_f.funct = 10'($urandom);
            in_f.a1    = 5'($urandom);
            in_f.a2    = 5'($urandom);
            in_f.rd    = 5'($urandom);
            in_f.valid = ($urandom_range(0, 3) != 0);
            @(posedge clk); #1;
            if (is_bubble(stall, flush, in_f.valid)) bubbles++;
            m = model_next(m, in_f, stall, flush);
            chk_f("rand_fields", out_f, m);
            chk_n("rand_cnt", int'(cnt), sat(bubbles, 65535));
            chk_n("rand_cnt4", int'(cnt4), sat(bubbles, 15));
            if (!out_f.valid && (out_f.ctrl[7] || out_f.ctrl[5] || out_f.ctrl[4] || out_f.ctrl[3]))
                chk_n("invariant_ctrl_when_invalid", 1, 0);
        end

        $display("test done: total=%0d bad=%0d", ntot, nbad);
        $finish;
    end

endmodule

`default_nettype wire
